gbox_word_load_gen: RTL and testbench
=====================================

GBOX_WORD_LOAD_GEN -- requirements
Module: gbox_word_load_gen

Interface
REQ-001 SHALL have parameter PAR_DWID, default 10, meaning serializer parallel word width; only 5 and 10 are legal.
REQ-002 SHALL have parameter WARMUP_WORDS, default 4, meaning word periods run with loads suppressed before lock; range 1..15.
REQ-003 SHALL have port fast_clk  input  1  fast serial-bit clock, the only clock.
REQ-004 SHALL have port system_reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port enable  input  1  synchronous run request.
REQ-006 SHALL have port cfg_bypass  input  1  gearbox bypass; forces idle.
REQ-007 SHALL have port rate_sel  input  4  bits per word.
REQ-008 SHALL have port align_req  input  1  single-cycle word-phase realign request.
REQ-009 SHALL have port word_load_en  output  1  one-cycle word-load strobe to the serializer.
REQ-010 SHALL have port core_clk_div  output  1  divided word-rate clock.
REQ-011 SHALL have port bit_phase  output  4  current bit index within the word.
REQ-012 SHALL have port locked  output  1  high while in RUN.
REQ-013 SHALL have port rate_err  output  1  high while in ERR.

Function
REQ-014 SHALL treat rate_sel as valid iff 3 <= rate_sel <= PAR_DWID.
REQ-015 SHALL hold a 4-bit bit counter cnt and a latched rate rate_q; word boundary = cnt == rate_q-1.
REQ-016 SHALL increment cnt every cycle in WARMUP/RUN, wrap to 0 at a boundary, and hold cnt at 0 in IDLE/ERR.
REQ-017 SHALL implement states IDLE, WARMUP, RUN, ERR; reset state IDLE.
REQ-018 SHALL go to IDLE on the next edge from any state when enable=0 or cfg_bypass=1; this has top priority.
REQ-019 IDLE: enable=1, cfg_bypass=0, rate valid -> WARMUP; load rate_q<=rate_sel; cnt<=0; warmup count<=0.
REQ-020 IDLE: enable=1, cfg_bypass=0, rate invalid -> ERR.
REQ-021 ERR: rate_sel valid -> IDLE. ERR never enters WARMUP directly.
REQ-022 WARMUP: count boundaries; at the WARMUP_WORDS-th boundary -> RUN with cnt=0.
REQ-023 RUN: at a boundary, rate_sel valid and != rate_q -> WARMUP with the new rate_q, cnt=0, warmup count=0.
REQ-024 RUN: at a boundary, rate_sel invalid -> ERR.
REQ-025 rate_sel changes between boundaries SHALL be ignored until the next boundary.
REQ-026 align_req in WARMUP/RUN SHALL set cnt<=0, reset the warmup count and go to WARMUP; rate_q keeps its value.
REQ-027 align_req SHALL win over a simultaneous boundary event. align_req is ignored in IDLE/ERR and when REQ-018 applies.
REQ-028 word_load_en SHALL be driven directly by a flop and be high iff state==RUN and cnt==0, giving exactly one pulse per rate_q cycles.
REQ-029 core_clk_div SHALL be driven by a flop.
  - high while cnt < ceil(rate_q/2), otherwise low
  - 0 in IDLE/ERR
  - duty example: R=5 gives 3 high, 2 low
REQ-030 bit_phase SHALL equal cnt.
REQ-031 locked SHALL be high iff state==RUN.
REQ-032 rate_err SHALL be high iff state==ERR.
REQ-033 With enable sampled high at edge E0 and rate R, the first word_load_en SHALL be high in the cycle after edge E0+WARMUP_WORDS*R.

Reset
REQ-034 system_reset=1 SHALL asynchronously force the following, with no clock required:
  - state=IDLE, cnt=0, rate_q=0, warmup count=0
  - word_load_en=0, core_clk_div=0, bit_phase=0, locked=0, rate_err=0
REQ-035 Reset release SHALL leave the block in IDLE. Reset asserted mid-word SHALL produce no further word_load_en pulse.

Verification
REQ-036 Lock and period: enable=1, rate_sel=10, defaults.
  - first word_load_en 40 edges after E0
  - then one pulse every 10 cycles
  - locked=1
  - core_clk_div 5 high / 5 low
REQ-037 Invalid rate: rate_sel=2, enable=1 -> rate_err=1 next cycle, no word_load_en; then rate_sel=5 -> IDLE, then WARMUP, first pulse 20 edges later.
REQ-038 Rate change: RUN at R=10; rate_sel=7 mid-word.
  - pulses continue at 10 until the boundary
  - locked=0 for 28 cycles, then pulses every 7
REQ-039 Realign: align_req at bit_phase=3 in RUN.
  - bit_phase=0 next cycle, locked=0
  - relock after 4*rate_q cycles
  - align_req coinciding with a boundary also realigns
REQ-040 Drop and reset: cfg_bypass=1 in RUN -> all outputs 0 next edge; system_reset pulsed mid-word -> outputs 0 immediately; after release, idle until enable is resampled.
REQ-041 PAR_DWID=5: rate_sel=6 -> ERR; rate_sel=3 -> pulses every 3 cycles, core_clk_div 2 high / 1 low.

Source files
------------

// File: rtl/gbox_word_load_gen.sv
// Word-load strobe generator for a gearbox serializer.
// Counts serial bits on fast_clk, runs a few suppressed warm-up words after
// any (re)start, then issues one word_load_en pulse per word and a divided
// word-rate clock. Legal PAR_DWID: 5 or 10. Legal WARMUP_WORDS: 1..15.
module gbox_word_load_gen #(
  parameter int PAR_DWID     = 10,
  parameter int WARMUP_WORDS = 4
) (
  input  logic       fast_clk,
  input  logic       system_reset,
  input  logic       enable,
  input  logic       cfg_bypass,
  input  logic [3:0] rate_sel,
  input  logic       align_req,
  output logic       word_load_en,
  output logic       core_clk_div,
  output logic [3:0] bit_phase,
  output logic       locked,
  output logic       rate_err,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam logic [3:0] MAX_RATE  = 4'(PAR_DWID);
  localparam logic [3:0] WARM_LAST = 4'(WARMUP_WORDS - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] rate_q, rate_n;
  logic [3:0] wcnt, wcnt_n;
  logic [3:0] half_n;
  logic       rate_ok;
  logic       boundary;
  logic       wle_n, ckd_n;

  assign rate_ok   = (rate_sel >= 4'd3) && (rate_sel <= MAX_RATE);
  assign boundary  = (cnt == rate_q - 4'd1);
  assign bit_phase = cnt;
  assign fsm_state = state;

  // Next-state / counter logic; disable and bypass override everything,
  // and a realign request beats a coincident word boundary.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rate_n  = rate_q;
    wcnt_n  = wcnt;
    if (!enable || cfg_bypass) begin
      state_n = ST_IDLE;
      cnt_n   = 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_n = 4'd0;
          if (rate_ok) begin
            state_n = ST_WARMUP;
            rate_n  = rate_sel;
            wcnt_n  = 4'd0;
          end else begin
            state_n = ST_ERR;
          end
        end
        ST_ERR: begin
          cnt_n = 4'd0;
          // Always pass through IDLE so the new rate is latched there.
          if (rate_ok) state_n = ST_IDLE;
        end
        ST_WARMUP: begin
          if (align_req) begin
            cnt_n  = 4'd0;
            wcnt_n = 4'd0;
          end else if (boundary) begin
            cnt_n = 4'd0;
            if (wcnt == WARM_LAST) state_n = ST_RUN;
            else                   wcnt_n  = wcnt + 4'd1;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        ST_RUN: begin
          if (align_req) begin
            state_n = ST_WARMUP;
            cnt_n   = 4'd0;
            wcnt_n  = 4'd0;
          end else if (boundary) begin
            cnt_n = 4'd0;
            // rate_sel is only looked at on word boundaries.
            if (!rate_ok) begin
              state_n = ST_ERR;
            end else if (rate_sel != rate_q) begin
              state_n = ST_WARMUP;
              rate_n  = rate_sel;
              wcnt_n  = 4'd0;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = 4'd0;
        end
      endcase
    end
    // Outputs are precomputed from next values so the flops line up with cnt.
    half_n = (rate_n + 4'd1) >> 1;
    wle_n  = (state_n == ST_RUN) && (cnt_n == 4'd0);
    ckd_n  = ((state_n == ST_WARMUP) || (state_n == ST_RUN)) && (cnt_n < half_n);
  end

  // State, counters and registered outputs.
  always_ff @(posedge fast_clk or posedge system_reset) begin
    if (system_reset) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      rate_q       <= 4'd0;
      wcnt         <= 4'd0;
      word_load_en <= 1'b0;
      core_clk_div <= 1'b0;
      locked       <= 1'b0;
      rate_err     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      rate_q       <= rate_n;
      wcnt         <= wcnt_n;
      word_load_en <= wle_n;
      core_clk_div <= ckd_n;
      locked       <= (state_n == ST_RUN);
      rate_err     <= (state_n == ST_ERR);
    end
  end

endmodule

// File: tb/tb_gbox_word_load_gen.sv
// Bench for gbox_word_load_gen: pulse timing is scoreboarded by cycle number,
// level outputs are checked directly by the driver.
module tb_gbox_word_load_gen;

  // ---------------- clock / reset ----------------
  logic fast_clk = 1'b0;
  logic system_reset = 1'b0;
  always #5 fast_clk = ~fast_clk;

  int cyc = 0;
  always @(posedge fast_clk) cyc <= cyc + 1;

  // ---------------- DUT (PAR_DWID=10) ----------------
  logic       enable = 1'b0, cfg_bypass = 1'b0, align_req = 1'b0;
  logic [3:0] rate_sel = 4'd0;
  logic       word_load_en, core_clk_div, locked, rate_err;
  logic [3:0] bit_phase;
  logic [1:0] fsm_state;

  gbox_word_load_gen #(.PAR_DWID(10), .WARMUP_WORDS(4)) u_dut (
    .fast_clk(fast_clk), .system_reset(system_reset), .enable(enable),
    .cfg_bypass(cfg_bypass), .rate_sel(rate_sel), .align_req(align_req),
    .word_load_en(word_load_en), .core_clk_div(core_clk_div),
    .bit_phase(bit_phase), .locked(locked), .rate_err(rate_err),
    .fsm_state(fsm_state)
  );

  // ---------------- DUT (PAR_DWID=5) ----------------
  logic       enable5 = 1'b0, cfg_bypass5 = 1'b0, align_req5 = 1'b0;
  logic [3:0] rate_sel5 = 4'd0;
  logic       word_load_en5, core_clk_div5, locked5, rate_err5;
  logic [3:0] bit_phase5;
  logic [1:0] fsm_state5;

  gbox_word_load_gen #(.PAR_DWID(5), .WARMUP_WORDS(4)) u_dut5 (
    .fast_clk(fast_clk), .system_reset(system_reset), .enable(enable5),
    .cfg_bypass(cfg_bypass5), .rate_sel(rate_sel5), .align_req(align_req5),
    .word_load_en(word_load_en5), .core_clk_div(core_clk_div5),
    .bit_phase(bit_phase5), .locked(locked5), .rate_err(rate_err5),
    .fsm_state(fsm_state5)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp5_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the cycle number at the queue head.
  always @(negedge fast_clk) begin
    logic [31:0] e;
    if (word_load_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected actual=%0d expected=none", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e !== 32'(cyc)) begin
          errors++;
          $display("FAIL pulse_cycle actual=%0d expected=%0d", cyc, e);
        end
      end
    end
  end

  always @(negedge fast_clk) begin
    logic [31:0] e;
    if (word_load_en5 === 1'b1) begin
      checks++;
      if (exp5_q.size() == 0) begin
        errors++;
        $display("FAIL pulse5_unexpected actual=%0d expected=none", cyc);
      end else begin
        e = exp5_q.pop_front();
        if (e !== 32'(cyc)) begin
          errors++;
          $display("FAIL pulse5_cycle actual=%0d expected=%0d", cyc, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    if (cyc > n) begin
      checks++;
      errors++;
      $display("FAIL wait_to actual=%0d expected<=%0d", cyc, n);
    end
    while (cyc < n) tick();
  endtask

  function automatic logic [7:0] outs();
    return {word_load_en, core_clk_div, bit_phase, locked, rate_err};
  endfunction

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int e0, e1, e2, e3;

    // Async reset before any clock edge.
    #2 system_reset = 1'b1;
    #1 check("reset_outputs", 32'(outs()), 32'd0);
    check("reset_state", 32'(fsm_state), 32'd0);
    check("reset5_outputs", 32'({word_load_en5, core_clk_div5, bit_phase5, locked5, rate_err5}), 32'd0);
    repeat (3) tick();
    system_reset = 1'b0;
    repeat (3) tick();
    check("idle_after_release", 32'(outs()), 32'd0);

    // Lock at R=10: first strobe WARMUP_WORDS*R edges after E0.
    rate_sel = 4'd10;
    enable   = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back(32'(e0 + 40));
    exp_q.push_back(32'(e0 + 50));
    exp_q.push_back(32'(e0 + 60));
    exp_q.push_back(32'(e0 + 70));
    tick();
    check("warmup_bit_phase0", 32'(bit_phase), 32'd0);
    wait_to(e0 + 39);
    check("warmup_not_locked", 32'(locked), 32'd0);
    tick();
    check("locked_r10", 32'(locked), 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("clkdiv_r10", 32'(core_clk_div), (k < 5) ? 32'd1 : 32'd0);
      tick();
    end

    // Mid-word rate change: takes effect at the next boundary (E0+80).
    wait_to(e0 + 73);
    check("phase_before_change", 32'(bit_phase), 32'd3);
    rate_sel = 4'd7;
    wait_to(e0 + 79);
    check("still_locked_pre_boundary", 32'(locked), 32'd1);
    tick();
    check("relock_unlocked", 32'(locked), 32'd0);
    check("relock_phase0", 32'(bit_phase), 32'd0);
    exp_q.push_back(32'(e0 + 108));
    exp_q.push_back(32'(e0 + 115));
    exp_q.push_back(32'(e0 + 122));
    exp_q.push_back(32'(e0 + 129));
    wait_to(e0 + 107);
    check("r7_warmup_28", 32'(locked), 32'd0);
    tick();
    check("r7_locked", 32'(locked), 32'd1);

    // Realign mid-word.
    wait_to(e0 + 132);
    check("align_phase3", 32'(bit_phase), 32'd3);
    align_req = 1'b1;
    tick();
    align_req = 1'b0;
    check("align_phase0", 32'(bit_phase), 32'd0);
    check("align_unlocked", 32'(locked), 32'd0);
    exp_q.push_back(32'(e0 + 161));
    exp_q.push_back(32'(e0 + 168));

    // Realign exactly on a boundary suppresses that strobe.
    wait_to(e0 + 174);
    check("align_at_boundary_phase", 32'(bit_phase), 32'd6);
    align_req = 1'b1;
    tick();
    align_req = 1'b0;
    check("align_bnd_unlocked", 32'(locked), 32'd0);
    check("align_bnd_phase0", 32'(bit_phase), 32'd0);
    exp_q.push_back(32'(e0 + 203));
    wait_to(e0 + 203);
    check("align_bnd_relock", 32'(locked), 32'd1);

    // Bypass drops to idle on the next edge.
    wait_to(e0 + 205);
    cfg_bypass = 1'b1;
    tick();
    check("bypass_outputs", 32'(outs()), 32'd0);
    check("drain_a", 32'(exp_q.size()), 32'd0);
    cfg_bypass = 1'b0;
    e1 = cyc + 1;
    exp_q.push_back(32'(e1 + 28));
    wait_to(e1 + 30);

    // Async reset mid-word: outputs clear without a clock edge.
    #2 system_reset = 1'b1;
    enable = 1'b0;
    #1 check("midword_reset", 32'(outs()), 32'd0);
    check("midword_reset_state", 32'(fsm_state), 32'd0);
    tick();
    tick();
    system_reset = 1'b0;
    repeat (15) tick();
    check("post_reset_idle", 32'(outs()), 32'd0);
    check("drain_b", 32'(exp_q.size()), 32'd0);

    // Invalid rates -> ERR; valid rate -> IDLE then WARMUP.
    rate_sel = 4'd2;
    enable   = 1'b1;
    tick();
    check("err_rate2", 32'(rate_err), 32'd1);
    check("err_state", 32'(fsm_state), 32'd3);
    rate_sel = 4'd11;
    tick();
    check("err_rate11", 32'(rate_err), 32'd1);
    rate_sel = 4'd5;
    tick();
    check("err_to_idle", 32'(rate_err), 32'd0);
    check("err_to_idle_state", 32'(fsm_state), 32'd0);
    e2 = cyc + 1;
    exp_q.push_back(32'(e2 + 20));
    exp_q.push_back(32'(e2 + 25));
    wait_to(e2 + 20);
    check("locked_r5", 32'(locked), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("clkdiv_r5", 32'(core_clk_div), (k < 3) ? 32'd1 : 32'd0);
      tick();
    end
    wait_to(e2 + 27);
    enable = 1'b0;
    tick();
    check("disable_idle", 32'(outs()), 32'd0);
    check("drain_c", 32'(exp_q.size()), 32'd0);

    // PAR_DWID=5 instance.
    rate_sel5 = 4'd6;
    enable5   = 1'b1;
    tick();
    check("p5_err_rate6", 32'(rate_err5), 32'd1);
    rate_sel5 = 4'd3;
    tick();
    check("p5_err_to_idle", 32'(rate_err5), 32'd0);
    e3 = cyc + 1;
    exp5_q.push_back(32'(e3 + 12));
    exp5_q.push_back(32'(e3 + 15));
    exp5_q.push_back(32'(e3 + 18));
    wait_to(e3 + 12);
    check("p5_locked", 32'(locked5), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("p5_clkdiv_r3", 32'(core_clk_div5), (k < 2) ? 32'd1 : 32'd0);
      tick();
    end
    wait_to(e3 + 18);
    tick();
    enable5 = 1'b0;
    repeat (4) tick();
    check("p5_drain", 32'(exp5_q.size()), 32'd0);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
